// File: rtl/dlk_pkg.sv
// Shared types for the overflow report unit: FSM states,
// the queued event record and default sizing.
package dlk_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REPORT,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] pc;
  } event_t;

endpackage

// File: rtl/overflow_report_unit_if.sv
// Check/report bundle between the load checker, this unit
// and the commit stage.
interface overflow_report_unit_if;
  import dlk_pkg::*;

  logic            chk_valid;
  logic [XLEN-1:0] chk_addr;
  logic [XLEN-1:0] chk_pc;
  logic            overflow;
  logic            exc_valid;
  logic [XLEN-1:0] exc_addr;
  logic [XLEN-1:0] exc_pc;
  logic            exc_ack;

  modport master (
    output chk_valid, chk_addr, chk_pc,
    output overflow, exc_ack,
    input  exc_valid, exc_addr, exc_pc
  );

  modport slave (
    input  chk_valid, chk_addr, chk_pc,
    input  overflow, exc_ack,
    output exc_valid, exc_addr, exc_pc
  );

endinterface

// File: rtl/dlk_event_fifo.sv
// Power-of-two event FIFO; pointers carry an extra wrap
// bit so full and empty are told apart without a counter.
module dlk_event_fifo
  import dlk_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  event_t data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output event_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  event_t        mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_i};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_i};
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Payload needs no reset: it is only visible through a valid pointer.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/overflow_report_unit.sv
// Queues bounds-overflow events and reports them one at a
// time to commit, with a violation counter and overrun flag.
module overflow_report_unit
  import dlk_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             chk_valid_i,
  input  logic [31:0]      chk_addr_i,
  input  logic [31:0]      chk_pc_i,
  input  logic             overflow_i,
  output logic             exc_valid_o,
  output logic [31:0]      exc_addr_o,
  output logic [31:0]      exc_pc_o,
  input  logic             exc_ack_i,
  output logic [CNT_W-1:0] viol_cnt_o,
  output logic             overrun_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic   evt, push, pop, drop;
  logic   full, empty;
  event_t evt_data, head;

  assign evt      = chk_valid_i & overflow_i;
  assign evt_data = {chk_addr_i, chk_pc_i};
  assign pop      = (state_q == ST_REPORT) & exc_ack_i & ~clear_i;
  // A full queue still takes the event when the head leaves this cycle.
  assign push     = evt & (~full | pop) & ~clear_i;
  assign drop     = evt & full & ~pop;

  dlk_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .data_i  (evt_data),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_REPORT;
      ST_REPORT: if (exc_ack_i) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    ovr_d = ovr_q | drop;
    if (evt && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    if (clear_i) begin
      cnt_d = '0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign exc_valid_o = (state_q == ST_REPORT);
  assign exc_addr_o  = exc_valid_o ? head.addr : '0;
  assign exc_pc_o    = exc_valid_o ? head.pc : '0;
  assign viol_cnt_o  = cnt_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_overflow_report_unit.sv
// Randomized and directed bench for overflow_report_unit
// against a queue-based reference model.
module tb_overflow_report_unit;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [15:0] cnt;
  logic        ovr;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [3:0]  s_cnt;
  logic        s_ovr;

  overflow_report_unit_if bus ();

  always #5 clk_i = ~clk_i;

  overflow_report_unit #(
    .DEPTH (DEPTH),
    .CNT_W (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .chk_valid_i (bus.chk_valid),
    .chk_addr_i  (bus.chk_addr),
    .chk_pc_i    (bus.chk_pc),
    .overflow_i  (bus.overflow),
    .exc_valid_o (bus.exc_valid),
    .exc_addr_o  (bus.exc_addr),
    .exc_pc_o    (bus.exc_pc),
    .exc_ack_i   (bus.exc_ack),
    .viol_cnt_o  (cnt),
    .overrun_o   (ovr)
  );

  overflow_report_unit #(
    .DEPTH (DEPTH),
    .CNT_W (4)
  ) dut_s (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .chk_valid_i (bus.chk_valid),
    .chk_addr_i  (bus.chk_addr),
    .chk_pc_i    (bus.chk_pc),
    .overflow_i  (bus.overflow),
    .exc_valid_o (s_valid),
    .exc_addr_o  (s_addr),
    .exc_pc_o    (s_pc),
    .exc_ack_i   (bus.exc_ack),
    .viol_cnt_o  (s_cnt),
    .overrun_o   (s_ovr)
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: pending events in order, whether the head is
  // on display, and whether we sit in the post-ack gap.
  logic [63:0] mq [$];
  bit          m_show;
  bit          m_gap;
  int          m_cnt;
  bit          m_ovr;
  bit          m_ev, m_pop, m_had;

  always @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      mq.delete();
      m_show = 0;
      m_gap  = 0;
      m_cnt  = 0;
      m_ovr  = 0;
    end else begin
      m_ev  = bus.chk_valid & bus.overflow;
      m_pop = m_show & bus.exc_ack;
      m_had = (mq.size() != 0);
      if (m_pop) void'(mq.pop_front());
      if (m_ev) begin
        m_cnt++;
        if (mq.size() < DEPTH) mq.push_back({bus.chk_addr, bus.chk_pc});
        else m_ovr = 1;
      end
      if (m_pop) begin
        m_show = 0;
        m_gap  = 1;
      end else if (!m_show) begin
        if (m_gap) m_gap = 0;
        else m_show = m_had;
      end
    end
  end

  logic [63:0] e_head;
  logic [31:0] e_addr, e_pc;
  int          e_cnt, e_scnt;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      e_head = (m_show && mq.size() != 0) ? mq[0] : 64'd0;
      e_addr = e_head[63:32];
      e_pc   = e_head[31:0];
      e_cnt  = (m_cnt > 65535) ? 65535 : m_cnt;
      e_scnt = (m_cnt > 15) ? 15 : m_cnt;
      chk("m_valid", bus.exc_valid, m_show);
      chk("m_addr", bus.exc_addr, e_addr);
      chk("m_pc", bus.exc_pc, e_pc);
      chk("m_cnt", cnt, e_cnt);
      chk("m_ovr", ovr, m_ovr);
      chk("m_s_valid", s_valid, m_show);
      chk("m_s_addr", s_addr, e_addr);
      chk("m_s_pc", s_pc, e_pc);
      chk("m_s_cnt", s_cnt, e_scnt);
      chk("m_s_ovr", s_ovr, m_ovr);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    bus.chk_valid = 0;
    bus.overflow  = 0;
    bus.exc_ack   = 0;
    clear_i       = 0;
  endtask

  task automatic ev(input logic [31:0] a, input logic [31:0] p);
    bus.chk_valid = 1;
    bus.overflow  = 1;
    bus.chk_addr  = a;
    bus.chk_pc    = p;
  endtask

  task automatic do_clear();
    idle_in();
    clear_i = 1;
    step();
    clear_i = 0;
    step();
  endtask

  task automatic drain(input int n, input logic [31:0] base,
                       input int first);
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < 8 && !bus.exc_valid; t++) step();
      chk("drain_valid", bus.exc_valid, 1);
      chk("drain_addr", bus.exc_addr, base + 32'(4 * (first + k)));
      bus.exc_ack = 1;
      step();
      bus.exc_ack = 0;
    end
    for (int t = 0; t < 10; t++) begin
      chk("drain_extra", bus.exc_valid, 0);
      step();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 0;
    bus.chk_addr = 0;
    bus.chk_pc   = 0;
    idle_in();
    repeat (3) step();
    rst_ni = 1;
    step();
    chk("rst_valid", bus.exc_valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovr", ovr, 0);

    // Single event: visible two cycles later, drops after ack.
    ev(32'h8000_1010, 32'h8000_0200);
    step();
    idle_in();
    chk("t1_n1_valid", bus.exc_valid, 0);
    chk("t1_cnt", cnt, 1);
    step();
    chk("t1_n2_valid", bus.exc_valid, 1);
    chk("t1_addr", bus.exc_addr, 32'h8000_1010);
    chk("t1_pc", bus.exc_pc, 32'h8000_0200);
    step();
    step();
    chk("t1_hold", bus.exc_valid, 1);
    bus.exc_ack = 1;
    step();
    bus.exc_ack = 0;
    chk("t1_low", bus.exc_valid, 0);
    chk("t1_addr0", bus.exc_addr, 0);
    do_clear();

    // Overflow without a checked load is ignored.
    bus.overflow = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t2_valid", bus.exc_valid, 0);
    end
    chk("t2_cnt", cnt, 0);
    do_clear();

    // Six events into a four-deep queue.
    for (int i = 0; i < 6; i++) begin
      ev(32'h1000 + 32'(4 * i), 32'h2000 + 32'(i));
      step();
    end
    idle_in();
    chk("t3_cnt", cnt, 6);
    chk("t3_ovr", ovr, 1);
    chk("t3_head", bus.exc_addr, 32'h1000);
    drain(4, 32'h1000, 0);
    do_clear();

    // Full queue, event coincident with ack is accepted.
    for (int i = 0; i < 4; i++) begin
      ev(32'h3000 + 32'(4 * i), 32'h4000 + 32'(i));
      step();
    end
    chk("t4_valid", bus.exc_valid, 1);
    ev(32'h3010, 32'h4004);
    bus.exc_ack = 1;
    step();
    idle_in();
    chk("t4_ovr", ovr, 0);
    chk("t4_cnt", cnt, 5);
    drain(4, 32'h3000, 1);
    do_clear();

    // Clear wins over a simultaneous ack and event.
    ev(32'h5000, 32'h5555);
    step();
    idle_in();
    step();
    chk("t5_pre", bus.exc_valid, 1);
    ev(32'h6000, 32'h6666);
    bus.exc_ack = 1;
    clear_i = 1;
    step();
    idle_in();
    chk("t5_valid", bus.exc_valid, 0);
    chk("t5_cnt", cnt, 0);
    chk("t5_ovr", ovr, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_empty", bus.exc_valid, 0);
    end

    // Narrow counter saturates.
    for (int i = 0; i < 17; i++) begin
      ev(32'h7000 + 32'(i), 32'h7100);
      step();
    end
    idle_in();
    chk("t6_scnt", s_cnt, 4'hF);
    chk("t6_cnt", cnt, 17);
    do_clear();

    // Asynchronous reset while a report is pending.
    ev(32'h9000, 32'h9999);
    step();
    idle_in();
    step();
    chk("t7_pre", bus.exc_valid, 1);
    #2;
    rst_ni = 0;
    #1;
    chk("t7_valid", bus.exc_valid, 0);
    chk("t7_addr", bus.exc_addr, 0);
    chk("t7_pc", bus.exc_pc, 0);
    chk("t7_cnt", cnt, 0);
    step();
    rst_ni = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t7_after", bus.exc_valid, 0);
    end

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      bus.chk_valid = 1'($urandom_range(0, 1));
      bus.overflow  = 1'($urandom_range(0, 1));
      bus.chk_addr  = $urandom;
      bus.chk_pc    = $urandom;
      bus.exc_ack   = ($urandom_range(0, 9) < 4);
      clear_i       = ($urandom_range(0, 199) == 0);
      step();
    end
    idle_in();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
